// File: rtl/paddle_controller.sv
// Pong paddle position register driven by encoder detents, with detent-rate
// acceleration, playfield clamping and a debounced one-cycle serve pulse.
module paddle_controller #(
    parameter int Y_W          = 10,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 420,
    parameter int Y_RESET      = 210,
    parameter int STEP         = 4,
    parameter int WIN_W        = 22,
    parameter int ACCEL_WINDOW = 2500000,
    parameter int DEB_W        = 20,
    parameter int DEBOUNCE     = 500000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           up,
    input  logic           down,
    input  logic           button,
    input  logic           center,
    output logic [Y_W-1:0] paddle_y,
    output logic           moved,
    output logic           serve
);
    typedef enum logic [1:0] {SLOW = 2'd0, MED = 2'd1, FAST = 2'd2} speed_t;

    localparam int YX = Y_W + 1;
    localparam logic [WIN_W-1:0] WIN_SAT  = WIN_W'(ACCEL_WINDOW);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [Y_W-1:0]   Y_RST_V  = Y_W'(Y_RESET);
    localparam logic [Y_W-1:0]   Y_MIN_V  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]   Y_MAX_V  = Y_W'(Y_MAX);
    localparam logic [Y_W:0]     Y_MIN_X  = YX'(Y_MIN);
    localparam logic [Y_W:0]     Y_MAX_X  = YX'(Y_MAX);
    localparam logic [Y_W:0]     STEP_X   = YX'(STEP);

    speed_t           speed, speed_next;
    logic [WIN_W-1:0] win_cnt, win_next;
    logic             last_dn, last_dn_next;
    logic [Y_W-1:0]   y_next;
    logic             up_q, up_q2, down_q, down_q2;
    logic             rise_up, rise_dn, detent;
    logic [Y_W:0]     y_ext, delta, y_wide;

    logic             btn_m, btn_s, btn_db;
    logic [DEB_W-1:0] deb_cnt;

    assign rise_up = up_q & ~up_q2;
    assign rise_dn = down_q & ~down_q2;
    // Opposing detents in the same cycle cancel out entirely.
    assign detent  = rise_up ^ rise_dn;
    assign y_ext   = {1'b0, paddle_y};

    always_comb begin
        speed_next   = speed;
        win_next     = win_cnt;
        last_dn_next = last_dn;
        y_next       = paddle_y;
        delta        = STEP_X;
        y_wide       = y_ext;
        if (center) begin
            speed_next = SLOW;
            win_next   = WIN_SAT;
            y_next     = Y_RST_V;
        end else if (detent) begin
            if (rise_dn == last_dn && win_cnt < WIN_SAT) begin
                case (speed)
                    SLOW:    speed_next = MED;
                    default: speed_next = FAST;
                endcase
            end else begin
                speed_next = SLOW;
            end
            win_next     = '0;
            last_dn_next = rise_dn;
            // The promoted (or demoted) speed already applies to this detent.
            case (speed_next)
                SLOW:    delta = STEP_X;
                MED:     delta = STEP_X << 1;
                default: delta = STEP_X << 2;
            endcase
            if (rise_dn) begin
                y_wide = y_ext + delta;
                y_next = (y_wide > Y_MAX_X) ? Y_MAX_V : y_wide[Y_W-1:0];
            end else begin
                y_wide = y_ext - delta;
                y_next = (y_ext < Y_MIN_X + delta) ? Y_MIN_V : y_wide[Y_W-1:0];
            end
        end else begin
            if (win_cnt != WIN_SAT) win_next = win_cnt + WIN_W'(1);
            if (win_next == WIN_SAT) speed_next = SLOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q     <= 1'b0;
            up_q2    <= 1'b0;
            down_q   <= 1'b0;
            down_q2  <= 1'b0;
            speed    <= SLOW;
            win_cnt  <= WIN_SAT;
            last_dn  <= 1'b0;
            paddle_y <= Y_RST_V;
            moved    <= 1'b0;
        end else begin
            up_q     <= up;
            up_q2    <= up_q;
            down_q   <= down;
            down_q2  <= down_q;
            speed    <= speed_next;
            win_cnt  <= win_next;
            last_dn  <= last_dn_next;
            paddle_y <= y_next;
            moved    <= (y_next != paddle_y);
        end
    end

    // A level is accepted only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
            btn_db  <= 1'b0;
            deb_cnt <= '0;
            serve   <= 1'b0;
        end else begin
            btn_m <= button;
            btn_s <= btn_m;
            serve <= 1'b0;
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
                serve   <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: directed scenarios plus random detent traffic
// checked against an event-level model of paddle position and speed.
module tb_paddle_controller;
    localparam int Y_W     = 10;
    localparam int Y_MIN   = 0;
    localparam int Y_MAX   = 420;
    localparam int Y_RESET = 210;
    localparam int STEP    = 4;
    localparam int WIN     = 16;
    localparam int DEB     = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           up = 1'b0;
    logic           down = 1'b0;
    logic           button = 1'b0;
    logic           center = 1'b0;
    logic [Y_W-1:0] paddle_y;
    logic           moved;
    logic           serve;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int serve_n = 0;
    int serve_cyc = -1;
    int moved_n = 0;

    // Model: position, speed level (0..2), last direction, cycle of last detent.
    int m_y;
    int m_level;
    bit m_dn;
    int m_last;
    logic [31:0] exp_q[$];

    paddle_controller #(
        .Y_W(Y_W), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_RESET(Y_RESET), .STEP(STEP),
        .WIN_W(22), .ACCEL_WINDOW(WIN), .DEB_W(20), .DEBOUNCE(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .up(up), .down(down), .button(button),
        .center(center), .paddle_y(paddle_y), .moved(moved), .serve(serve)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (serve) begin
            serve_n   <= serve_n + 1;
            serve_cyc <= cyc;
        end
        if (moved) moved_n <= moved_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        m_y = Y_RESET;
        m_level = 0;
        m_dn = 1'b0;
        m_last = -1000000;
    endfunction

    function automatic void model_center();
        m_y = Y_RESET;
        m_level = 0;
        m_last = -1000000;
    endfunction

    // A detent accepted at cycle 'at' speeds up only if it follows a same-way
    // detent by at most WIN cycles; the step is STEP * 1, 2 or 4.
    function automatic void model_detent(input bit dn, input int at);
        int d;
        if (dn == m_dn && (at - m_last) <= WIN) m_level = (m_level < 2) ? m_level + 1 : 2;
        else m_level = 0;
        m_dn = dn;
        m_last = at;
        d = STEP * (1 << m_level);
        if (dn) m_y = (m_y + d > Y_MAX) ? Y_MAX : m_y + d;
        else m_y = (m_y - d < Y_MIN) ? Y_MIN : m_y - d;
    endfunction

    task automatic detent(input bit dn, input int idle);
        int old;
        repeat (idle) tick();
        if (dn) down = 1'b1;
        else up = 1'b1;
        tick();
        up = 1'b0;
        down = 1'b0;
        check("latency_y", paddle_y, m_y);
        check("latency_moved", moved, 0);
        tick();
        old = m_y;
        model_detent(dn, cyc);
        exp_q.push_back(m_y);
        check("detent_y", paddle_y, exp_q.pop_front());
        check("detent_moved", moved, (m_y != old));
        tick();
        check("moved_pulse", moved, 0);
    endtask

    task automatic do_center();
        int old;
        old = m_y;
        center = 1'b1;
        tick();
        center = 1'b0;
        model_center();
        check("center_y", paddle_y, m_y);
        check("center_moved", moved, (m_y != old));
        tick();
        check("center_pulse", moved, 0);
    endtask

    task automatic both();
        up = 1'b1;
        down = 1'b1;
        tick();
        up = 1'b0;
        down = 1'b0;
        tick();
        check("both_y", paddle_y, m_y);
        check("both_moved", moved, 0);
    endtask

    initial begin
        int c0;
        int n0;
        int old;
        int r;
        model_reset();

        // 1. reset state, single up detent, held up
        tick();
        tick();
        check("rst_y", paddle_y, Y_RESET);
        check("rst_moved", moved, 0);
        check("rst_serve", serve, 0);
        rst_n = 1'b1;
        tick();
        detent(1'b0, 0);
        check("s1_y", paddle_y, 206);
        n0 = moved_n;
        c0 = cyc;
        up = 1'b1;
        repeat (10) tick();
        up = 1'b0;
        tick();
        tick();
        old = m_y;
        model_detent(1'b0, c0 + 2);
        check("hold_y", paddle_y, m_y);
        check("hold_moves", moved_n - n0, (m_y != old) ? 1 : 0);

        // 2. acceleration and window expiry
        do_center();
        detent(1'b1, 2);
        check("s2_y1", paddle_y, 214);
        detent(1'b1, 2);
        check("s2_y2", paddle_y, 222);
        detent(1'b1, 2);
        check("s2_y3", paddle_y, 238);
        detent(1'b1, 2);
        check("s2_y4", paddle_y, 254);
        detent(1'b1, 17);
        check("s2_y5", paddle_y, 258);

        // 3. reversal and simultaneous detents
        detent(1'b1, 17);
        check("s3_dn", paddle_y, 262);
        detent(1'b0, 2);
        check("s3_up", paddle_y, 258);
        both();

        // 4. clamping at both limits
        do_center();
        detent(1'b1, 17);
        detent(1'b1, 17);
        for (int i = 0; i < 13; i++) detent(1'b1, 2);
        check("s4_pre_max", paddle_y, 418);
        detent(1'b1, 2);
        check("s4_max_y", paddle_y, Y_MAX);
        detent(1'b1, 2);
        check("s4_max_hold", paddle_y, Y_MAX);
        for (int i = 0; i < 27; i++) detent(1'b0, 2);
        check("s4_pre_min", paddle_y, 8);
        detent(1'b0, 2);
        check("s4_min_y", paddle_y, Y_MIN);
        detent(1'b0, 2);
        check("s4_min_hold", paddle_y, Y_MIN);

        // 5. button debounce
        n0 = serve_n;
        button = 1'b1; tick();
        button = 1'b0; tick();
        button = 1'b1; tick();
        button = 1'b0; tick();
        button = 1'b1;
        c0 = cyc;
        repeat (12) tick();
        check("serve_count", serve_n - n0, 1);
        check("serve_lat", ((serve_cyc - c0) >= 10 && (serve_cyc - c0) <= 11), 1);
        n0 = serve_n;
        button = 1'b0; tick();
        button = 1'b1; tick();
        button = 1'b0; tick();
        button = 1'b1; tick();
        button = 1'b0;
        repeat (16) tick();
        check("release_no_serve", serve_n - n0, 0);
        button = 1'b1;
        repeat (5) tick();
        button = 1'b0;
        repeat (16) tick();
        check("glitch_no_serve", serve_n - n0, 0);
        button = 1'b1;
        repeat (14) tick();
        check("second_press", serve_n - n0, 1);
        button = 1'b0;
        repeat (14) tick();

        // 6. center overriding a detent, then mid-run reset
        detent(1'b1, 17);
        down = 1'b1;
        tick();
        down = 1'b0;
        center = 1'b1;
        old = m_y;
        tick();
        center = 1'b0;
        model_center();
        check("s6_center_y", paddle_y, Y_RESET);
        check("s6_center_moved", moved, (old != Y_RESET));
        tick();
        detent(1'b1, 0);
        check("s6_after_center", paddle_y, 214);
        down = 1'b1;
        tick();
        down = 1'b0;
        tick();
        check("s6_moved_before_rst", moved, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s6_rst_y", paddle_y, Y_RESET);
        check("s6_rst_moved", moved, 0);
        check("s6_rst_serve", serve, 0);
        tick();
        rst_n = 1'b1;
        tick();
        down = 1'b1;
        tick();
        rst_n = 1'b0;
        down = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("s6_inflight_lost_y", paddle_y, Y_RESET);
        check("s6_inflight_lost_moved", moved, 0);

        // random traffic against the model
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) do_center();
            else if (r == 1) both();
            else detent(1'($urandom_range(0, 1)), $urandom_range(0, 16));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/paddle_controller.md
Name: paddle_controller

Overview:
Consumes the single-cycle up/down detent pulses and the raw push-button from the rotary encoder front end, and maintains the Pong paddle's vertical position register. It adds detent-rate acceleration, clamps the position to the playfield, and debounces the button into a one-cycle serve pulse. Its outputs feed the game-logic and renderer stages.

Parameters:
Y_W, 10, width of paddle_y.
Y_MIN, 0, smallest legal paddle_y (top of playfield).
Y_MAX, 420, largest legal paddle_y (480 minus 60-pixel paddle).
Y_RESET, 210, position after reset or center.
STEP, 4, base pixels per detent.
WIN_W, 22, width of the acceleration window counter.
ACCEL_WINDOW, 2500000, maximum gap in cycles between same-direction detents that still promotes speed.
DEB_W, 20, width of the debounce counter.
DEBOUNCE, 500000, consecutive stable cycles required to accept a button level.

Ports:
clk  in  1  system clock; all state is updated on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
up  in  1  detent-up pulse from the encoder stage; synchronous to clk.
down  in  1  detent-down pulse from the encoder stage; synchronous to clk.
button  in  1  raw encoder switch; asynchronous and bouncy.
center  in  1  synchronous recenter request from game logic.
paddle_y  out  Y_W  current paddle top coordinate; registered.
moved  out  1  one-cycle pulse whenever paddle_y changes value.
serve  out  1  one-cycle pulse on each debounced button press.

Behaviour:
- Reset (rst_n=0, async): paddle_y=Y_RESET, moved=0, serve=0, speed=SLOW, window counter saturated at ACCEL_WINDOW, last_dir=up, debounced button=0, all input registers=0.
- Input stage: up and down are each registered once into up_q and down_q, with a second register for edge detect. rise_up = up_q & ~up_q2; rise_dn likewise.
- Simultaneous rise_up and rise_dn in the same cycle: both are ignored and no state changes.
- Latency: up first high at edge n, so up_q goes high at edge n; paddle_y and moved update at edge n+1. Holding up high for many cycles counts as a single detent.
- Speed FSM has states SLOW, MED and FAST, with multipliers 1, 2 and 4 (delta = STEP shifted by 0, 1 or 2).
  - Accepted detent, same direction as last_dir, window counter < ACCEL_WINDOW: promote one level (FAST saturates).
  - Accepted detent in any other case (opposite direction, or window expired): go to SLOW.
  - The new level's delta applies to that same detent.
  - last_dir is updated on every accepted detent.
- Window counter is cleared to 0 on every accepted detent and otherwise increments, saturating at ACCEL_WINDOW. When it reaches ACCEL_WINDOW the FSM drops to SLOW.
- Direction: up decreases paddle_y (screen top = 0); down increases it.
- Arithmetic is done in Y_W+1 bits.
  - Up: if paddle_y < Y_MIN + delta, result = Y_MIN; otherwise result = paddle_y - delta.
  - Down: if paddle_y + delta > Y_MAX, result = Y_MAX; otherwise result = paddle_y + delta.
  - No wrap-around is possible.
- moved = 1 for exactly one cycle only if the new paddle_y differs from the old value. A detent against a limit still updates the FSM and counter but gives moved = 0.
- center has the highest priority and overrides a detent in the same cycle: paddle_y=Y_RESET, speed=SLOW, window counter saturated. moved pulses only if the value changed.
- Button path:
  - 2-flop synchronizer into btn_s.
  - Debounce counter clears whenever btn_s equals the debounced level, and otherwise increments.
  - When the count reaches DEBOUNCE-1 while btn_s still differs, the debounced level takes btn_s and the counter clears.
  - serve = 1 for one cycle on a debounced 0→1 transition. Release produces no pulse.
- Reset asserted mid-operation returns everything to reset values immediately. Detents in flight are lost, not replayed.

Test Plan:
Use the bench configuration STEP=4, ACCEL_WINDOW=16, DEBOUNCE=8 for all scenarios.
1. Reset, then one 1-cycle up pulse → paddle_y 210→206 two edges after the pulse; moved high for exactly 1 cycle; up held 10 cycles → single step only.
2. Three down pulses spaced 5 cycles apart → steps of 4, 8, 16 (paddle_y 214, 222, 238); a fourth pulse → +16 (254). Wait 20 cycles, then down → +4 (258).
3. Down pulse then up pulse 5 cycles apart → +4 then -4 (SLOW on reversal); simultaneous up+down pulse → no change, moved=0.
4. Drive paddle_y to 418 via center plus detents, then FAST down pulse → clamps at 420 with moved=1; next pulse → stays 420, moved=0. Mirror the test at Y_MIN=0.
5. Button bounces 1010 over 4 cycles, then holds 1 for 12 cycles → exactly one serve pulse about 10–11 cycles after the stable level; bounce on release → no pulse.
6. center asserted in the same cycle as an accepted down detent → paddle_y=210, next detent uses step 4; rst_n pulsed low mid-sequence → immediate paddle_y=210, moved=0, serve=0.
